ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/exmem_skid.sv | 110 +++++++++++
 rtl/ex_mem_reg.sv | 89 ++++++++
 tb/tb_ex_mem_reg.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: datapath widths, the EX/MEM payload record and
// the occupancy states of the EX/MEM pipeline register.
package cpu_pkg;

    localparam int WORD_W    = 16;
    localparam int REG_IDX_W = 4;

    typedef struct packed {
        logic [WORD_W-1:0]    alu_result;
        logic [WORD_W-1:0]    store_data;
        logic                 memwrite;
        logic                 memread;
        logic                 memtoreg;
        logic                 regwrite;
        logic [REG_IDX_W-1:0] rd;
    } exmem_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/exmem_skid.sv
// Occupancy FSM and payload storage for the EX/MEM register. Single entry by
// default; defining EXMEM_SKID_EN adds a second skid slot and a registered in_ready.
module exmem_skid
    import cpu_pkg::*;
#(
    parameter type payload_t = exmem_payload_t
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     in_valid,
    output logic     in_ready,
    input  payload_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output payload_t out_data
);

    occ_state_t state_q, state_d;
    payload_t   head_q, head_d;
`ifdef EXMEM_SKID_EN
    payload_t   skid_q, skid_d;
    logic       in_ready_q, in_ready_d;
`endif
    logic       in_fire;
    logic       out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;

`ifdef EXMEM_SKID_EN
    assign in_ready = in_ready_q & ~rst;
`else
    assign in_ready = ~rst & (~out_valid | out_ready);
`endif

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can infer a latch.
        state_d = state_q;
        head_d  = head_q;
`ifdef EXMEM_SKID_EN
        skid_d  = skid_q;
`endif
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    head_d  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    head_d = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
`ifdef EXMEM_SKID_EN
                end else if (in_fire) begin
                    state_d = TWO;
                    skid_d  = in_data;
`endif
                end
            end
`ifdef EXMEM_SKID_EN
            TWO: begin
                if (out_fire) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase

        // A flushed cycle must not disturb the held fields visible downstream.
        if (flush) begin
            state_d = EMPTY;
            head_d  = head_q;
`ifdef EXMEM_SKID_EN
            skid_d  = skid_q;
`endif
        end
`ifdef EXMEM_SKID_EN
        in_ready_d = (state_d != TWO);
`endif
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            // NOTE: payload storage is reset because held fields drive the outputs directly.
            head_q  <= '0;
`ifdef EXMEM_SKID_EN
            skid_q     <= '0;
            in_ready_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
`ifdef EXMEM_SKID_EN
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
`endif
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: bubble-safe control gating and a saturating stall
// counter around exmem_skid (two-entry skid buffer when EXMEM_SKID_EN is defined).
module ex_mem_reg
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    alu_result,
    input  logic [WORD_W-1:0]    store_data,
    input  logic                 memwrite_in,
    input  logic                 memread_in,
    input  logic                 memtoreg_in,
    input  logic                 regwrite_in,
    input  logic [REG_IDX_W-1:0] rd_in,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    address,
    output logic [WORD_W-1:0]    datawrite,
    output logic                 memwrite,
    output logic                 memread,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic [REG_IDX_W-1:0] rd,
    output logic [WORD_W-1:0]    stall_count
);

    localparam logic [WORD_W-1:0] STALL_MAX = '1;

    exmem_payload_t    in_payload;
    exmem_payload_t    head;
    logic              head_valid;
    logic [WORD_W-1:0] stall_count_q, stall_count_d;

    always_comb begin
        in_payload            = '0;
        in_payload.alu_result = alu_result;
        in_payload.store_data = store_data;
        in_payload.memwrite   = memwrite_in;
        in_payload.memread    = memread_in;
        in_payload.memtoreg   = memtoreg_in;
        in_payload.regwrite   = regwrite_in;
        in_payload.rd         = rd_in;
    end

    exmem_skid #(
        .payload_t (exmem_payload_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (head_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    // Only the side-effecting controls are gated; the rest simply hold.
    assign out_valid = head_valid;
    assign address   = head.alu_result;
    assign datawrite = head.store_data;
    assign memwrite  = head_valid & head.memwrite;
    assign memread   = head_valid & head.memread;
    assign memtoreg  = head.memtoreg;
    assign regwrite  = head_valid & head.regwrite;
    assign rd        = head.rd;

    always_comb begin
        stall_count_d = stall_count_q;
        if (head_valid && !out_ready && (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + WORD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_ex_mem_reg;
    import cpu_pkg::*;

    typedef struct {
        logic           rst;
        logic           in_valid;
        logic           flush;
        logic           out_ready;
        exmem_payload_t p;
    } drv_t;

    typedef struct {
        drv_t        d;
        logic        ir;
        logic        ov;
        logic [15:0] addr;
        logic [15:0] dw;
        logic [3:0]  ctrl;
        logic [3:0]  rdx;
        logic [15:0] stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] alu_result, store_data, address, datawrite, stall_count;
    logic        memwrite_in, memread_in, memtoreg_in, regwrite_in;
    logic        memwrite, memread, memtoreg, regwrite;
    logic [3:0]  rd_in, rd;

    int n_checks = 0;
    int n_fail   = 0;

    exmem_payload_t mq[$];
    exmem_payload_t shown = '0;
    int             stall = 0;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .memwrite_in (memwrite_in),
        .memread_in  (memread_in),
        .memtoreg_in (memtoreg_in),
        .regwrite_in (regwrite_in),
        .rd_in       (rd_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .address     (address),
        .datawrite   (datawrite),
        .memwrite    (memwrite),
        .memread     (memread),
        .memtoreg    (memtoreg),
        .regwrite    (regwrite),
        .rd          (rd),
        .stall_count (stall_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic drv_t mk(input logic r, input logic iv, input logic fl, input logic ordy,
                                input logic [15:0] a, input logic [15:0] sd,
                                input logic [3:0] ctrl, input logic [3:0] rdv);
        drv_t d;
        d.rst          = r;
        d.in_valid     = iv;
        d.flush        = fl;
        d.out_ready    = ordy;
        d.p.alu_result = a;
        d.p.store_data = sd;
        d.p.memwrite   = ctrl[3];
        d.p.memread    = ctrl[2];
        d.p.memtoreg   = ctrl[1];
        d.p.regwrite   = ctrl[0];
        d.p.rd         = rdv;
        return d;
    endfunction

    // Capacity-based acceptance rule of each build.
    function automatic logic model_in_ready(input logic r, input logic ordy);
        if (r) return 1'b0;
`ifdef EXMEM_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || ordy;
`endif
    endfunction

    task automatic model_edge(input drv_t d);
        logic acc;
        acc = d.in_valid && model_in_ready(d.rst, d.out_ready);
        if (d.rst) begin
            mq.delete();
            shown = '0;
            stall = 0;
            return;
        end
        if (mq.size() > 0 && !d.out_ready && stall < 65535) stall++;
        if (d.flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && d.out_ready) void'(mq.pop_front());
            if (acc) mq.push_back(d.p);
        end
        if (mq.size() > 0) shown = mq[0];
    endtask

    task automatic apply(input drv_t d);
        rst         = d.rst;
        in_valid    = d.in_valid;
        flush       = d.flush;
        out_ready   = d.out_ready;
        alu_result  = d.p.alu_result;
        store_data  = d.p.store_data;
        memwrite_in = d.p.memwrite;
        memread_in  = d.p.memread;
        memtoreg_in = d.p.memtoreg;
        regwrite_in = d.p.regwrite;
        rd_in       = d.p.rd;
    endtask

    task automatic check_outputs();
        logic v;
        v = (mq.size() > 0);
        check("out_valid", out_valid, v);
        check("address", address, shown.alu_result);
        check("datawrite", datawrite, shown.store_data);
        check("memwrite", memwrite, v & shown.memwrite);
        check("memread", memread, v & shown.memread);
        check("memtoreg", memtoreg, shown.memtoreg);
        check("regwrite", regwrite, v & shown.regwrite);
        check("rd", rd, shown.rd);
        check("stall_count", stall_count, 32'(stall));
    endtask

    // One clock: drive at negedge, sample in_ready before the edge, outputs after it.
    task automatic cycle(input drv_t d, input bit chk, output logic ir_seen);
        @(negedge clk);
        apply(d);
        #1;
        ir_seen = in_ready;
        if (chk) check("in_ready", in_ready, model_in_ready(d.rst, d.out_ready));
        model_edge(d);
        @(posedge clk);
        #1;
        if (chk) check_outputs();
    endtask

    vec_t tbl [10];
    drv_t idle_hold, idle_go, rst_d;
    logic ir;

    initial begin
        idle_hold = mk(0, 0, 0, 0, 16'h0, 16'h0, 4'h0, 4'h0);
        idle_go   = mk(0, 0, 0, 1, 16'h0, 16'h0, 4'h0, 4'h0);
        rst_d     = mk(1, 0, 0, 1, 16'h0, 16'h0, 4'h0, 4'h0);

        // ctrl nibble order: {memwrite, memread, memtoreg, regwrite}
        tbl[0] = '{mk(1,0,0,1,16'h0000,16'h0000,4'h0,4'h0), 0, 0, 16'h0000, 16'h0000, 4'h0, 4'h0, 16'h0};
        tbl[1] = '{mk(1,1,0,1,16'h1234,16'h5678,4'hF,4'h9), 0, 0, 16'h0000, 16'h0000, 4'h0, 4'h0, 16'h0};
        tbl[2] = '{mk(0,1,0,1,16'h0005,16'h00AB,4'h8,4'h0), 1, 1, 16'h0005, 16'h00AB, 4'h8, 4'h0, 16'h0};
        tbl[3] = '{mk(0,1,0,1,16'h0020,16'h0000,4'h7,4'h3), 1, 1, 16'h0020, 16'h0000, 4'h7, 4'h3, 16'h0};
        tbl[4] = '{mk(0,0,0,1,16'h0000,16'h0000,4'h0,4'h0), 1, 0, 16'h0020, 16'h0000, 4'h2, 4'h3, 16'h0};
        tbl[5] = '{mk(0,0,0,0,16'h0000,16'h0000,4'h0,4'h0), 1, 0, 16'h0020, 16'h0000, 4'h2, 4'h3, 16'h0};
        tbl[6] = '{mk(0,1,1,1,16'h0030,16'hBEEF,4'h8,4'h5), 1, 0, 16'h0020, 16'h0000, 4'h2, 4'h3, 16'h0};
        tbl[7] = '{mk(0,1,0,1,16'h0040,16'hCAFE,4'h8,4'h7), 1, 1, 16'h0040, 16'hCAFE, 4'h8, 4'h7, 16'h0};
        tbl[8] = '{mk(0,0,1,1,16'h0000,16'h0000,4'h0,4'h0), 1, 0, 16'h0040, 16'hCAFE, 4'h0, 4'h7, 16'h0};
        tbl[9] = '{mk(1,0,0,1,16'h0000,16'h0000,4'h0,4'h0), 0, 0, 16'h0000, 16'h0000, 4'h0, 4'h0, 16'h0};

        apply(rst_d);

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].d, 1, ir);
            check($sformatf("tbl%0d_in_ready", i), ir, tbl[i].ir);
            check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
            check($sformatf("tbl%0d_address", i), address, tbl[i].addr);
            check($sformatf("tbl%0d_datawrite", i), datawrite, tbl[i].dw);
            check($sformatf("tbl%0d_ctrl", i), {memwrite, memread, memtoreg, regwrite}, tbl[i].ctrl);
            check($sformatf("tbl%0d_rd", i), rd, tbl[i].rdx);
            check($sformatf("tbl%0d_stall", i), stall_count, tbl[i].stall);
        end

        // Back-to-back stream of 8 loads, no bubbles.
        cycle(rst_d, 1, ir);
        for (int i = 0; i < 8; i++) begin
            cycle(mk(0, 1, 0, 1, 16'(i), 16'h0, 4'h7, 4'(i)), 1, ir);
            check($sformatf("stream%0d_valid", i), out_valid, 1'b1);
            check($sformatf("stream%0d_addr", i), address, 32'(i));
        end
        cycle(idle_go, 1, ir);
        check("stream_drained", out_valid, 1'b0);

        // Two entries under backpressure, then release: A then B in order.
        cycle(rst_d, 1, ir);
        cycle(mk(0, 1, 0, 0, 16'h0010, 16'h0A0A, 4'h8, 4'h1), 1, ir);
        check("skid_a_head", address, 16'h0010);
        cycle(mk(0, 1, 0, 0, 16'h0011, 16'h0B0B, 4'h8, 4'h2), 1, ir);
`ifdef EXMEM_SKID_EN
        check("skid_b_accepted", ir, 1'b1);
`else
        check("skid_b_refused", ir, 1'b0);
`endif
        cycle(mk(0, 1, 0, 0, 16'h0012, 16'h0C0C, 4'h8, 4'h3), 1, ir);
        check("skid_full_in_ready", ir, 1'b0);
        cycle(idle_hold, 1, ir);
        check("skid_stall_3", stall_count, 16'd3);
        check("skid_a_still_head", address, 16'h0010);
        cycle(idle_go, 1, ir);
`ifdef EXMEM_SKID_EN
        check("skid_b_next_valid", out_valid, 1'b1);
        check("skid_b_next_addr", address, 16'h0011);
        cycle(idle_go, 1, ir);
`endif
        check("skid_drained", out_valid, 1'b0);

        // Flush with entries held and a same-cycle incoming entry.
        cycle(rst_d, 1, ir);
        cycle(mk(0, 1, 0, 0, 16'h0010, 16'h1111, 4'h8, 4'h1), 1, ir);
        cycle(mk(0, 1, 0, 0, 16'h0011, 16'h2222, 4'h8, 4'h2), 1, ir);
        cycle(mk(0, 1, 1, 0, 16'h00DD, 16'hDDDD, 4'h8, 4'hD), 1, ir);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_memwrite", memwrite, 1'b0);
        check("flush_keeps_stall", stall_count, 16'd2);
        for (int i = 0; i < 3; i++) begin
            cycle(idle_go, 1, ir);
            check($sformatf("flush_no_emit%0d", i), out_valid, 1'b0);
        end

        // Reset while holding two entries.
        cycle(mk(0, 1, 0, 0, 16'h0010, 16'h1111, 4'h8, 4'h1), 1, ir);
        cycle(mk(0, 1, 0, 0, 16'h0011, 16'h2222, 4'h8, 4'h2), 1, ir);
        cycle(idle_hold, 1, ir);
        cycle(mk(1, 1, 1, 0, 16'h0033, 16'h3333, 4'h8, 4'h3), 1, ir);
        check("rst_in_ready_low", ir, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_stall", stall_count, 16'd0);
        check("rst_address", address, 16'd0);
        cycle(idle_hold, 1, ir);
        check("rst_in_ready_after", ir, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drv_t d;
            d = mk(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                   ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 6),
                   16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
            cycle(d, 1, ir);
        end

        // Long stall saturates the counter.
        cycle(rst_d, 1, ir);
        cycle(mk(0, 1, 0, 0, 16'h0077, 16'h7777, 4'h8, 4'h7), 1, ir);
        for (int i = 0; i < 70000; i++) cycle(idle_hold, 0, ir);
        check("stall_saturated", stall_count, 16'hFFFF);
        check_outputs();
        cycle(idle_go, 1, ir);
        check("stall_sat_hold", stall_count, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
